frame_seq_ctrl: RTL and testbench
=================================

Name: frame_seq_ctrl

Overview:
- Sequences one 28x28 downsampled frame from the pixel-coordinate stream into the frame buffer, then launches the classifier and collects its result.
- Sits between the downsampler/pixel counter (H/V coordinates, per-pixel strobe) and the frame RAM plus inference core.
- Owns the frame-buffer write port while capturing and hands the buffer to the classifier while inferring.

Parameters:
- IMG_W, 28, pixels per row; coordinates run 1..IMG_W.
- IMG_H, 28, rows per frame; coordinates run 1..IMG_H.
- ADDR_W, 10, frame-buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- PIX_W, 8, pixel data width.
- CLS_W, 4, classifier result width.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset; asynchronous, active-high.
- arm  in  1  request capture of the next complete frame; level-sampled in IDLE only.
- h_cont  in  5  current pixel column, 1-based.
- v_cont  in  5  current pixel row, 1-based.
- pix_stb  in  1  one-cycle strobe: h_cont, v_cont and pix_in are valid.
- pix_in  in  PIX_W  pixel value.
- buf_we  out  1  frame-buffer write enable.
- buf_addr  out  ADDR_W  write address, (v-1)*IMG_W+(h-1).
- buf_wdata  out  PIX_W  write data.
- infer_start  out  1  one-cycle pulse launching the classifier.
- infer_done  in  1  one-cycle pulse from the classifier; cls_in is valid.
- cls_in  in  CLS_W  classifier result.
- result  out  CLS_W  latched result.
- result_valid  out  1  one-cycle pulse when result updates.
- busy  out  1  high in every state except IDLE.
- frame_err  out  1  one-cycle pulse on a coordinate mismatch.
- drop_cnt  out  8  saturating count of SOF strobes seen in INFER.

Behaviour:
- Reset: state=IDLE; buf_we=0; buf_addr=0; buf_wdata=0; infer_start=0; result=0; result_valid=0; busy=0; frame_err=0; drop_cnt=0; expected coordinate=(1,1). Reset mid-frame abandons the frame; buffer contents are don't-care.
- SOF: a pix_stb with h_cont=1 and v_cont=1.
- States:
  - IDLE: arm=1 -> SYNC.
  - SYNC: ignore strobes until SOF; on SOF write the pixel to address 0, set expected=(2,1) -> CAPTURE.
  - CAPTURE: on each pix_stb compare (h,v) with expected.
    - Match: write the pixel, then advance expected: h wraps IMG_W->1 and increments v.
    - Match on (IMG_W,IMG_H): write the pixel -> INFER.
    - Mismatch that is an SOF: pulse frame_err, restart capture using this pixel as address 0, stay in CAPTURE with expected=(2,1).
    - Any other mismatch: pulse frame_err, no write -> SYNC.
  - INFER: infer_start pulses exactly once, the cycle after entering INFER; this is 1 cycle after the final buf_we. Each SOF strobe increments drop_cnt, saturating at 255. On infer_done: result<=cls_in and result_valid pulses in the next cycle -> IDLE. infer_done in the same cycle as infer_start is legal and is accepted.
- Write timing: buf_we, buf_addr and buf_wdata are registered and appear 1 cycle after the sampled pix_stb. buf_we is high for exactly one cycle per accepted pixel and is never asserted outside SYNC/CAPTURE writes.
- Address arithmetic: computed from the internal expected counter, not from the raw inputs; must be exact for IMG_W*IMG_H-1 = 783.
- pix_stb with no change in state has no effect. Out-of-range coordinates (0, or >IMG_W/IMG_H) are mismatches.
- arm is ignored outside IDLE.
- infer_done outside INFER is ignored.

Optional Feature:
- Macro: FRAME_SEQ_AUTO_REARM_EN.
- Defined: after result_valid, go to SYNC instead of IDLE. arm is needed only for the first frame; busy stays 1 continuously thereafter. Deasserting arm in INFER returns to IDLE after the result.
- Undefined: always return to IDLE as described above.

Test Plan:
- Arm, drive a clean 784-pixel frame with pix_in=(addr mod 256) -> 784 buf_we pulses, addresses 0..783 in order, matching data. infer_start pulses once, 1 cycle after the write to 783.
- Arm mid-frame (first strobe at h=5,v=3) -> no writes until the next (1,1). Capture then starts at address 0; frame_err stays 0.
- In CAPTURE, skip pixel (10,2) -> frame_err pulse at that strobe; state SYNC; the next SOF restarts at address 0.
- In INFER, deliver 3 SOFs before infer_done with cls_in=7 -> drop_cnt=3; result=7; result_valid single pulse; busy=0 afterwards.
- Assert reset at address 400 -> all outputs at reset values. Re-arm and run a clean frame -> behaves as in the first scenario.
- FRAME_SEQ_AUTO_REARM_EN defined, arm held, two frames -> two infer_start and two result_valid pulses; busy never drops between frames.

Source files
------------

// File: rtl/frame_seq_ctrl.sv
// frame_seq_ctrl: captures one IMG_W x IMG_H frame from a strobed
// (h_cont, v_cont, pix_in) stream into a frame buffer, then launches the
// classifier and latches its result.
//
// Optional feature macro: FRAME_SEQ_AUTO_REARM_EN
//   defined   : after result_valid, return to SYNC while arm is high, so
//               frames are captured back to back without re-arming.
//   undefined : always return to IDLE after the result.
//
// Handshake: every interface here is a single-cycle strobe with no
// back-pressure. pix_stb qualifies h_cont/v_cont/pix_in in the cycle it
// is high; infer_done qualifies cls_in in the cycle it is high. Outputs
// buf_we, infer_start, result_valid and frame_err are one-cycle pulses,
// all registered (they appear the cycle after the event that caused them).
module frame_seq_ctrl #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int ADDR_W = 10,
  parameter int PIX_W  = 8,
  parameter int CLS_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic [4:0]        h_cont,
  input  logic [4:0]        v_cont,
  input  logic              pix_stb,
  input  logic [PIX_W-1:0]  pix_in,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [PIX_W-1:0]  buf_wdata,
  output logic              infer_start,
  input  logic              infer_done,
  input  logic [CLS_W-1:0]  cls_in,
  output logic [CLS_W-1:0]  result,
  output logic              result_valid,
  output logic              busy,
  output logic              frame_err,
  output logic [7:0]        drop_cnt
);

  // Last column / row in coordinate units (coordinates are 1-based).
  localparam logic [4:0]        H_LAST = 5'(IMG_W);
  localparam logic [4:0]        V_LAST = 5'(IMG_H);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(IMG_W);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SYNC    = 2'd1,
    S_CAPTURE = 2'd2,
    S_INFER   = 2'd3
  } state_t;

  // FSM state; kept as a plainly named signal so checkers can bind to it.
  state_t state;
  state_t state_nxt;

  // Expected next coordinate while capturing.
  logic [4:0] exp_h;
  logic [4:0] exp_v;
  logic [4:0] exp_h_nxt;
  logic [4:0] exp_v_nxt;

  // Set once infer_start has been issued for the current INFER visit.
  logic launched;
  logic launched_nxt;

  logic              buf_we_nxt;
  logic [ADDR_W-1:0] buf_addr_nxt;
  logic [PIX_W-1:0]  buf_wdata_nxt;
  logic              infer_start_nxt;
  logic [CLS_W-1:0]  result_nxt;
  logic              result_valid_nxt;
  logic              frame_err_nxt;
  logic [7:0]        drop_cnt_nxt;

  // Decoded strobe qualifiers.
  logic              sof;
  logic              hit;
  logic              last_px;
  logic [ADDR_W-1:0] exp_addr;
  logic              rearm;

  // Start-of-frame, coordinate match and linear address of the expected pixel.
  always_comb begin
    sof      = pix_stb && (h_cont == 5'd1) && (v_cont == 5'd1);
    hit      = pix_stb && (h_cont == exp_h) && (v_cont == exp_v);
    last_px  = (exp_h == H_LAST) && (exp_v == V_LAST);
    exp_addr = ADDR_W'(exp_v - 5'd1) * STRIDE + ADDR_W'(exp_h - 5'd1);
`ifdef FRAME_SEQ_AUTO_REARM_EN
    rearm    = arm;
`else
    rearm    = 1'b0;
`endif
  end

  // Next-state and next-output logic for the capture/inference sequence.
  always_comb begin
    state_nxt        = state;
    exp_h_nxt        = exp_h;
    exp_v_nxt        = exp_v;
    launched_nxt     = launched;
    buf_we_nxt       = 1'b0;
    buf_addr_nxt     = buf_addr;
    buf_wdata_nxt    = buf_wdata;
    infer_start_nxt  = 1'b0;
    result_nxt       = result;
    result_valid_nxt = 1'b0;
    frame_err_nxt    = 1'b0;
    drop_cnt_nxt     = drop_cnt;

    case (state)
      S_IDLE: begin
        if (arm) begin
          state_nxt = S_SYNC;
        end
      end

      S_SYNC: begin
        // Anything other than the first pixel of a frame is discarded here.
        if (sof) begin
          buf_we_nxt    = 1'b1;
          buf_addr_nxt  = '0;
          buf_wdata_nxt = pix_in;
          exp_h_nxt     = 5'd2;
          exp_v_nxt     = 5'd1;
          state_nxt     = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        if (pix_stb) begin
          if (hit) begin
            buf_we_nxt    = 1'b1;
            buf_addr_nxt  = exp_addr;
            buf_wdata_nxt = pix_in;
            if (last_px) begin
              exp_h_nxt    = 5'd1;
              exp_v_nxt    = 5'd1;
              launched_nxt = 1'b0;
              state_nxt    = S_INFER;
            end else if (exp_h == H_LAST) begin
              exp_h_nxt = 5'd1;
              exp_v_nxt = exp_v + 5'd1;
            end else begin
              exp_h_nxt = exp_h + 5'd1;
            end
          end else if (sof) begin
            // A new frame started early: resynchronise on it immediately.
            frame_err_nxt = 1'b1;
            buf_we_nxt    = 1'b1;
            buf_addr_nxt  = '0;
            buf_wdata_nxt = pix_in;
            exp_h_nxt     = 5'd2;
            exp_v_nxt     = 5'd1;
          end else begin
            frame_err_nxt = 1'b1;
            exp_h_nxt     = 5'd1;
            exp_v_nxt     = 5'd1;
            state_nxt     = S_SYNC;
          end
        end
      end

      S_INFER: begin
        // The buffer belongs to the classifier now; launch it exactly once.
        if (!launched) begin
          infer_start_nxt = 1'b1;
          launched_nxt    = 1'b1;
        end
        if (sof && (drop_cnt != 8'hFF)) begin
          drop_cnt_nxt = drop_cnt + 8'd1;
        end
        if (infer_done) begin
          result_nxt       = cls_in;
          result_valid_nxt = 1'b1;
          state_nxt        = rearm ? S_SYNC : S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered-output flops; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      exp_h        <= 5'd1;
      exp_v        <= 5'd1;
      launched     <= 1'b0;
      buf_we       <= 1'b0;
      buf_addr     <= '0;
      buf_wdata    <= '0;
      infer_start  <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
      drop_cnt     <= 8'd0;
    end else begin
      state        <= state_nxt;
      exp_h        <= exp_h_nxt;
      exp_v        <= exp_v_nxt;
      launched     <= launched_nxt;
      buf_we       <= buf_we_nxt;
      buf_addr     <= buf_addr_nxt;
      buf_wdata    <= buf_wdata_nxt;
      infer_start  <= infer_start_nxt;
      result       <= result_nxt;
      result_valid <= result_valid_nxt;
      frame_err    <= frame_err_nxt;
      drop_cnt     <= drop_cnt_nxt;
    end
  end

  // busy is a pure decode of the state register.
  always_comb begin
    busy = (state != S_IDLE);
  end

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Bench for frame_seq_ctrl: directed scenarios plus randomized pixel
// streams, checked every cycle against a linear-index behavioural model.
module tb_frame_seq_ctrl;

  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int ADDR_W = 10;
  localparam int PIX_W  = 8;
  localparam int CLS_W  = 4;
  localparam int NPIX   = IMG_W * IMG_H;
`ifdef FRAME_SEQ_AUTO_REARM_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              arm = 1'b0;
  logic [4:0]        h_cont = '0;
  logic [4:0]        v_cont = '0;
  logic              pix_stb = 1'b0;
  logic [PIX_W-1:0]  pix_in = '0;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [PIX_W-1:0]  buf_wdata;
  logic              infer_start;
  logic              infer_done = 1'b0;
  logic [CLS_W-1:0]  cls_in = '0;
  logic [CLS_W-1:0]  result;
  logic              result_valid;
  logic              busy;
  logic              frame_err;
  logic [7:0]        drop_cnt;

  always #5 clk = ~clk;

  frame_seq_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .PIX_W(PIX_W), .CLS_W(CLS_W)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm), .h_cont(h_cont), .v_cont(v_cont),
    .pix_stb(pix_stb), .pix_in(pix_in), .buf_we(buf_we), .buf_addr(buf_addr),
    .buf_wdata(buf_wdata), .infer_start(infer_start), .infer_done(infer_done),
    .cls_in(cls_in), .result(result), .result_valid(result_valid), .busy(busy),
    .frame_err(frame_err), .drop_cnt(drop_cnt)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 waiting for arm, 1 hunting for frame start, 2 filling, 3 classifying
  int  m_phase = 0;
  int  m_idx = 0;
  bit  m_owed = 1'b0;
  bit  e_we = 1'b0;
  bit  e_start = 1'b0;
  bit  e_rv = 1'b0;
  bit  e_err = 1'b0;
  int  e_result = 0;
  int  e_drop = 0;
  logic [ADDR_W+PIX_W-1:0] exp_q[$];

  task automatic predict_write(input int a, input int d);
    e_we = 1'b1;
    exp_q.push_back({ADDR_W'(a), PIX_W'(d)});
  endtask

  always @(posedge clk or posedge reset) begin : model_blk
    int lin;
    bit sof;
    if (reset) begin
      m_phase = 0; m_idx = 0; m_owed = 1'b0;
      e_we = 1'b0; e_start = 1'b0; e_rv = 1'b0; e_err = 1'b0;
      e_result = 0; e_drop = 0;
      exp_q.delete();
    end else begin
      e_we = 1'b0; e_start = 1'b0; e_rv = 1'b0; e_err = 1'b0;
      sof = pix_stb && (h_cont == 5'd1) && (v_cont == 5'd1);
      lin = -1;
      if (h_cont >= 1 && int'(h_cont) <= IMG_W && v_cont >= 1 && int'(v_cont) <= IMG_H)
        lin = (int'(v_cont) - 1) * IMG_W + int'(h_cont) - 1;
      case (m_phase)
        0: if (arm) m_phase = 1;
        1: if (sof) begin predict_write(0, int'(pix_in)); m_idx = 1; m_phase = 2; end
        2: if (pix_stb) begin
             if (lin == m_idx) begin
               predict_write(m_idx, int'(pix_in));
               if (m_idx == NPIX - 1) begin m_phase = 3; m_owed = 1'b1; end
               else m_idx++;
             end else if (sof) begin
               e_err = 1'b1; predict_write(0, int'(pix_in)); m_idx = 1;
             end else begin
               e_err = 1'b1; m_phase = 1;
             end
           end
        default: begin
          if (m_owed) begin e_start = 1'b1; m_owed = 1'b0; end
          if (sof && e_drop < 255) e_drop++;
          if (infer_done) begin
            e_result = int'(cls_in); e_rv = 1'b1;
            m_phase = (AUTO && arm) ? 1 : 0;
          end
        end
      endcase
    end
  end

  // ---------------- compare process (every negedge) ----------------
  int cyc = 0;
  int we_count = 0, last_we_cyc = 0, last_we_addr = 0;
  int start_count = 0, start_cyc = 0, rv_count = 0, err_count = 0, busy_low = 0;

  always @(negedge clk) begin : cmp_blk
    logic [ADDR_W+PIX_W-1:0] w;
    cyc++;
    check("buf_we", int'(buf_we), int'(e_we));
    check("infer_start", int'(infer_start), int'(e_start));
    check("result", int'(result), e_result);
    check("result_valid", int'(result_valid), int'(e_rv));
    check("busy", int'(busy), int'(m_phase != 0));
    check("frame_err", int'(frame_err), int'(e_err));
    check("drop_cnt", int'(drop_cnt), e_drop);
    if (buf_we) begin
      check("write_queue_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check("buf_addr", int'(buf_addr), int'(w[ADDR_W+PIX_W-1:PIX_W]));
        check("buf_wdata", int'(buf_wdata), int'(w[PIX_W-1:0]));
      end
      we_count++; last_we_cyc = cyc; last_we_addr = int'(buf_addr);
    end
    if (infer_start) begin start_count++; start_cyc = cyc; end
    if (result_valid) rv_count++;
    if (frame_err) err_count++;
    if (!busy) busy_low++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input int h, input int v, input int p);
    h_cont = 5'(h); v_cont = 5'(v); pix_in = PIX_W'(p); pix_stb = 1'b1;
    tick();
    pix_stb = 1'b0; infer_done = 1'b0;
    repeat ($urandom_range(0, 1)) tick();
  endtask

  task automatic send_frame();
    for (int v = 1; v <= IMG_H; v++)
      for (int h = 1; h <= IMG_W; h++)
        send_pix(h, v, ((v - 1) * IMG_W + h - 1) % 256);
  endtask

  task automatic arm_pulse();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic wait_start(input int target);
    for (int i = 0; i < 20; i++) begin
      if (start_count >= target) break;
      tick();
    end
    check("infer_start_within_budget", int'(start_count >= target), 1);
  endtask

  task automatic classify(input int c);
    infer_done = 1'b1; cls_in = CLS_W'(c);
    tick();
    infer_done = 1'b0;
    repeat (3) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int w0, s0, e0, r0, b0, c, idx, h, v;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_busy", int'(busy), 0);
    check("reset_drop_cnt", int'(drop_cnt), 0);
    check("reset_result", int'(result), 0);

    // Clean frame: 784 writes, infer_start one cycle after the last write.
    arm_pulse();
    w0 = we_count; s0 = start_count; r0 = rv_count;
    send_frame();
    wait_start(s0 + 1);
    tick(); tick();
    check("frame1_writes", we_count - w0, 784);
    check("frame1_last_addr", last_we_addr, 783);
    check("frame1_starts", start_count - s0, 1);
    check("frame1_start_latency", start_cyc - last_we_cyc, 1);
    c = $urandom_range(0, 15);
    classify(c);
    check("frame1_result", int'(result), c);
    check("frame1_result_valid", rv_count - r0, 1);

    // Armed mid-frame: nothing written until the next frame start.
    arm_pulse();
    w0 = we_count; e0 = err_count; s0 = start_count;
    for (int x = 5; x <= IMG_W; x++) send_pix(x, 3, x);
    check("midframe_no_writes", we_count - w0, 0);
    send_frame();
    wait_start(s0 + 1);
    check("midframe_writes", we_count - w0, 784);
    check("midframe_no_err", err_count - e0, 0);
    classify(3);

    // Skipped pixel (10,2): one error, back to hunting, next frame restarts.
    arm_pulse();
    w0 = we_count; e0 = err_count; s0 = start_count;
    for (int i = 0; i < IMG_W + 9; i++) send_pix(i % IMG_W + 1, i / IMG_W + 1, i);
    send_pix(11, 2, 99);
    send_pix(12, 2, 98);
    tick(); tick();
    check("skip_err_pulses", err_count - e0, 1);
    check("skip_writes_before", we_count - w0, 37);
    send_frame();
    wait_start(s0 + 1);
    check("skip_writes_after", we_count - w0, 37 + 784);
    check("skip_err_after", err_count - e0, 1);
    check("skip_last_addr", last_we_addr, 783);
    classify(5);

    // Frame starts seen while classifying are counted as drops.
    arm_pulse();
    s0 = start_count;
    send_frame();
    wait_start(s0 + 1);
    r0 = rv_count;
    for (int i = 0; i < 3; i++) send_pix(1, 1, 200 + i);
    classify(7);
    check("drop_cnt_three", int'(drop_cnt), 3);
    check("drop_result", int'(result), 7);
    check("drop_result_valid", rv_count - r0, 1);
    check("drop_idle_after", int'(busy), 0);

    // Reset in the middle of a capture, then a clean frame.
    arm_pulse();
    for (int i = 0; i <= 400; i++) send_pix(i % IMG_W + 1, i / IMG_W + 1, i);
    check("pre_reset_addr", last_we_addr, 400);
    reset = 1'b1;
    #1;
    check("rst_buf_we", int'(buf_we), 0);
    check("rst_buf_addr", int'(buf_addr), 0);
    check("rst_buf_wdata", int'(buf_wdata), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_result", int'(result), 0);
    check("rst_drop_cnt", int'(drop_cnt), 0);
    check("rst_infer_start", int'(infer_start), 0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    arm_pulse();
    w0 = we_count; s0 = start_count;
    send_frame();
    wait_start(s0 + 1);
    check("post_reset_writes", we_count - w0, 784);
    check("post_reset_last_addr", last_we_addr, 783);
    check("post_reset_latency", start_cyc - last_we_cyc, 1);
    classify(9);
    check("post_reset_result", int'(result), 9);

`ifdef FRAME_SEQ_AUTO_REARM_EN
    // Arm held: two frames back to back without dropping busy.
    arm = 1'b1;
    tick();
    s0 = start_count; r0 = rv_count; b0 = busy_low;
    send_frame();
    wait_start(s0 + 1);
    classify(2);
    send_frame();
    wait_start(s0 + 2);
    classify(4);
    check("auto_starts", start_count - s0, 2);
    check("auto_results", rv_count - r0, 2);
    check("auto_busy_never_low", busy_low - b0, 0);
    arm = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0; tick();
`endif

    // Randomized streams with occasional glitches, early frame starts
    // and classifier answers at arbitrary moments.
    for (int r = 0; r < 4; r++) begin
      arm = 1'b1; tick(); arm = 1'($urandom_range(0, 1));
      idx = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(0, NPIX - 1);
      for (int n = 0; n < 900; n++) begin
        if ($urandom_range(0, 399) == 0) idx = 0;
        h = idx % IMG_W + 1; v = idx / IMG_W + 1;
        if ($urandom_range(0, 299) == 0) begin
          h = $urandom_range(0, 31); v = $urandom_range(0, 31);
        end
        infer_done = ($urandom_range(0, 59) == 0);
        cls_in = CLS_W'($urandom_range(0, 15));
        send_pix(h, v, $urandom_range(0, 255));
        idx = (idx + 1) % NPIX;
      end
      classify($urandom_range(0, 15));
      arm = 1'b0;
    end

    repeat (5) tick();
    check("write_queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
